// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M/RV64M multiply/divide execute unit
// Ports:
//   clk, rst (sync, active-high), flush_i
//   start_i, funct3_i, reg1_i, reg2_i, wd_i, wreg_i : instruction held in EX
//   stallreq_o, busy_o : pipeline hold / unit occupied
//   done_o, wdata_o, wd_o, wreg_o : one-cycle write-back result
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  output logic            stallreq_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [2:0]          funct3_q;
  logic                neg_q;
  logic                wreg_q;
  logic [XLEN-1:0]     opb_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;

  // Operand decode for the instruction presented in IDLE.
  logic            is_div, rs1_signed, rs2_signed, sa, sb, neg_i;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] a_abs, b_abs, fast_res;
  logic            accept;

  assign is_div     = funct3_i[2];
  assign rs1_signed = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
  assign rs2_signed = is_div ? ~funct3_i[0] : ~funct3_i[1];
  assign sa         = rs1_signed & reg1_i[XLEN-1];
  assign sb         = rs2_signed & reg2_i[XLEN-1];
  // Remainder follows the dividend; everything else is sign-xor (unsigned
  // operands contribute 0, which covers MULHSU and the unsigned variants).
  assign neg_i      = (is_div & funct3_i[1]) ? sa : (sa ^ sb);
  assign a_abs      = sa ? -reg1_i : reg1_i;
  assign b_abs      = sb ? -reg2_i : reg2_i;
  assign div_zero   = is_div && (reg2_i == '0);
  assign div_ovf    = is_div && !funct3_i[0] && (reg1_i == INT_MIN) && (reg2_i == '1);
  assign fast       = div_zero || div_ovf;
  assign accept     = (state_q == S_IDLE) && start_i && !flush_i;

  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = funct3_i[1] ? reg1_i : '1;
    else if (div_ovf)
      fast_res = funct3_i[1] ? '0 : reg1_i;
  end

  // One iteration step. The accumulator holds {product_hi, multiplier} for
  // multiply and {remainder, dividend/quotient} for divide, so both share
  // the same initial load {0, |rs1|}.
  logic [XLEN:0]       mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0]   acc_next, prod_fix;
  logic [XLEN-1:0]     div_sel, div_fix, final_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, opb_q};
    if (funct3_q[2])
      acc_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    // Negate the full double-width product so the high half is correct.
    prod_fix = neg_q ? -acc_next : acc_next;
    div_sel  = funct3_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    div_fix  = neg_q ? -div_sel : div_sel;
    if (funct3_q[2])
      final_res = div_fix;
    else if (funct3_q[1:0] == 2'b00)
      final_res = prod_fix[XLEN-1:0];
    else
      final_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stallreq_o = 1'b0;
    done_o     = 1'b0;
    wreg_o     = 1'b0;
    busy_o     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        stallreq_o = start_i & ~flush_i;
        if (accept) state_d = fast ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        if (flush_i)                    state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))    state_d = S_DONE;
      end
      S_DONE: begin
        // start_i here is the same instruction still sitting in EX.
        done_o  = ~flush_i;
        wreg_o  = wreg_q & ~flush_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q <= '0;
      neg_q    <= 1'b0;
      wreg_q   <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      wdata_o  <= '0;
      wd_o     <= '0;
    end else if (accept) begin
      funct3_q <= funct3_i;
      neg_q    <= neg_i;
      wreg_q   <= wreg_i;
      wd_o     <= wd_i;
      opb_q    <= b_abs;
      acc_q    <= {{XLEN{1'b0}}, a_abs};
      cnt_q    <= CNT_LOAD;
      if (fast) wdata_o <= fast_res;
    end else if (state_q == S_BUSY && !flush_i) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) wdata_o <= final_res;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit (XLEN=32)
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush_i, start_i, wreg_i;
  logic [2:0]  funct3_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        stallreq_o, busy_o, done_o, wreg_o;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_i),
    .funct3_i(funct3_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i),
    .stallreq_o(stallreq_o), .busy_o(busy_o), .done_o(done_o),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expectation for the instruction in flight, written only by the driver.
  logic        exp_valid = 1'b0;
  int          exp_t = 0, exp_cyc = 0, rst_chk_cyc = -1;
  logic [31:0] exp_data = '0, exp_model = '0;
  logic        exp_lit = 1'b0, exp_wreg = 1'b0;
  logic [4:0]  exp_wd = '0;
  logic        chk_en = 1'b0;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ub = longint'({32'd0, b});
    logic [63:0] t;
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ubu = {32'd0, b};
    case (f)
      3'd0: begin t = sa * sb; return t[31:0]; end
      3'd1: begin t = sa * sb; return t[63:32]; end
      3'd2: begin t = sa * ub; return t[63:32]; end
      3'd3: begin t = ua * ubu; return t[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        t = sa / sb; return t[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        t = sa % sb; return t[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  logic exp_done;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (cyc == rst_chk_cyc) begin
        check("reset_wdata", wdata_o, 0);
        check("reset_wd", wd_o, 0);
        check("reset_busy", busy_o, 0);
      end
      exp_done = exp_valid && (cyc == exp_cyc);
      check("done_o", done_o, exp_done);
      check("wreg_o", wreg_o, exp_done & exp_wreg);
      if (!flush_i) begin
        check("stallreq_o", stallreq_o, exp_valid && cyc < exp_cyc);
        check("busy_o", busy_o, exp_valid && cyc > exp_t && cyc <= exp_cyc);
      end
      if (exp_done) begin
        check("wdata_o", wdata_o, exp_data);
        check("wd_o", wd_o, exp_wd);
        if (exp_lit) check("model_pin", exp_model, exp_data);
      end
    end
  end

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wr, input logic [31:0] lit, input bit use_lit);
    bit fast;
    @(posedge clk); #1;
    funct3_i = f; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr; start_i = 1'b1;
    fast = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_model = ref_model(f, a, b);
    exp_data  = use_lit ? lit : exp_model;
    exp_lit   = use_lit;
    exp_wd    = wd;
    exp_wreg  = wr;
    exp_t     = cyc;
    exp_cyc   = cyc + (fast ? 1 : 33);
    exp_valid = 1'b1;
  endtask

  task automatic scramble();
    reg1_i = $urandom; reg2_i = $urandom; funct3_i = 3'($urandom);
    wd_i = 5'($urandom); wreg_i = 1'($urandom);
  endtask

  // Keep the instruction in EX through its DONE cycle, as the pipeline would.
  task automatic hold_to_done();
    int stop = exp_cyc;
    while (cyc <= stop) begin
      @(posedge clk); #1;
      scramble();
    end
    start_i = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
      scramble();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] r; } vec_t;
  vec_t dir [12];

  initial begin
    int t0;
    dir[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    dir[1]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
    dir[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    dir[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    dir[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    dir[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    dir[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    dir[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    dir[8]  = '{3'd4, 32'h1234,       32'd0,         32'hFFFF_FFFF};
    dir[9]  = '{3'd6, 32'h1234,       32'd0,         32'h1234};
    dir[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    dir[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

    rst = 1'b1; flush_i = 1'b0; start_i = 1'b0; wreg_i = 1'b0;
    funct3_i = '0; reg1_i = '0; reg2_i = '0; wd_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rst_chk_cyc = cyc;
    chk_en = 1'b1;

    foreach (dir[i]) begin
      launch(dir[i].f, dir[i].a, dir[i].b, 5'(i + 1), 1'(i % 3 != 2), dir[i].r, 1'b1);
      hold_to_done();
    end

    // Flush in the middle of a multiply, then a fresh divide two cycles later.
    launch(3'd0, 32'd12345, 32'd678, 5'd3, 1'b1, 32'd0, 1'b0);
    t0 = exp_t;
    start_i = 1'b1;
    wait_until(t0 + 10);
    flush_i = 1'b1; start_i = 1'b0; exp_valid = 1'b0;
    @(posedge clk); #1 flush_i = 1'b0;
    launch(3'd5, 32'd9, 32'd3, 5'd17, 1'b1, 32'd3, 1'b1);
    hold_to_done();

    // start and flush together in IDLE: nothing is accepted.
    @(posedge clk); #1 start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd4; reg2_i = 32'd0;
    @(posedge clk); #1 start_i = 1'b0; flush_i = 1'b0;
    repeat (40) @(posedge clk);

    // Reset in the middle of a divide.
    launch(3'd4, 32'd1000, 32'd7, 5'd9, 1'b1, 32'd0, 1'b0);
    t0 = exp_t;
    wait_until(t0 + 5);
    rst = 1'b1; start_i = 1'b0; exp_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    rst_chk_cyc = cyc;

    for (int n = 0; n < 80; n++) begin
      launch(3'($urandom), pick(), pick(), 5'($urandom), 1'($urandom), 32'd0, 1'b0);
      hold_to_done();
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
